// File: rtl/ramfifo_read_sched.sv
// Round-robin read scheduler for the multi-context RAM FIFO; 1-cycle grant-to-out_valid latency.
// Backpressure: no read is issued while out_valid is held and out_ready is low; a drain FSM empties all contexts on request.
module ramfifo_read_sched #(
    parameter int WIDTH   = 36,
    parameter int LOG_CTX = 3,
    localparam int NUM_CTX = 1 << LOG_CTX
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_CTX-1:0]       ctx_mask,
    input  logic [NUM_CTX-1:0]       fifo_has_data,
    input  logic [NUM_CTX-1:0]       fifo_empty,
    input  logic [NUM_CTX*WIDTH-1:0] fifo_data,
    output logic [LOG_CTX-1:0]       fifo_rcc_id,
    output logic                     fifo_read,
    output logic [WIDTH-1:0]         out_data,
    output logic [LOG_CTX-1:0]       out_ctx,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     drain_req,
    output logic                     drain_done,
    output logic                     busy
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t               state;
    logic [LOG_CTX-1:0]   rr_ptr;
    logic [NUM_CTX-1:0]   cand;
    logic [NUM_CTX-1:0]   rot;
    logic [LOG_CTX-1:0]   start;
    logic [LOG_CTX-1:0]   offs;
    logic [LOG_CTX-1:0]   grant;
    logic                 hit;
    logic                 slot;
    logic                 take;

    always_comb begin
        case (state)
            RUN:     cand = fifo_has_data & ctx_mask;
            DRAIN:   cand = fifo_has_data;
            default: cand = '0;
        endcase
    end

    // Rotate candidates so bit 0 is the context just after the last grant.
    assign start = rr_ptr + LOG_CTX'(1);

    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            rot[i] = cand[start + LOG_CTX'(i)];
        end
    end

    always_comb begin
        hit  = 1'b0;
        offs = '0;
        for (int i = NUM_CTX - 1; i >= 0; i--) begin
            if (rot[i]) begin
                hit  = 1'b1;
                offs = LOG_CTX'(i);
            end
        end
    end

    assign grant       = start + offs;
    assign slot        = enable & (~out_valid | out_ready);
    assign take        = reset & slot & hit;
    assign fifo_read   = take;
    assign fifo_rcc_id = take ? grant : rr_ptr;
    assign busy        = (state == DRAIN) | out_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            rr_ptr     <= '1;
            out_data   <= '0;
            out_ctx    <= '0;
            out_valid  <= 1'b0;
            drain_done <= 1'b0;
        end else if (enable) begin
            if (take) begin
                out_data  <= fifo_data[grant*WIDTH +: WIDTH];
                out_ctx   <= grant;
                out_valid <= 1'b1;
                rr_ptr    <= grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                RUN: begin
                    if (drain_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (!drain_req) begin
                        state <= RUN;
                    end else if ((&fifo_empty) && (cand == '0) &&
                                 (!out_valid || (out_ready && !take))) begin
                        state      <= DONE;
                        drain_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (!drain_req) begin
                        state      <= RUN;
                        drain_done <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
